chacha_block_finalize: RTL
==========================

Name: chacha_block_finalize

Overview:
- Downstream stage of the ChaCha round datapath, after the quarter-round array has completed 20 rounds on a 16-word state.
- Adds the original input state to the permuted state word-wise, modulo 2^32.
- Buffers the resulting 512-bit keystream block and serialises it as sixteen 32-bit words over a valid/ready stream.
- The output stream feeds the cipher XOR/packer logic.

Parameters:
- PIPELINE, 0, 0 = sum computed at accept and stored directly; 1 = raw states stored, sum registered one cycle later (ADD state), cuts the 32-bit adder path from the input.

Ports:
- aclk  input  1  clock, all logic on rising edge.
- areset  input  1  asynchronous reset, active-high.
- i_valid  input  1  block available on i_init/i_state.
- i_ready  output  1  block accepted when i_valid & i_ready.
- i_init  input  512  original state; word k = bits [32k+31:32k].
- i_state  input  512  state after 20 rounds; same word mapping.
- o_valid  output  1  o_data holds a keystream word.
- o_ready  input  1  downstream accepts when o_valid & o_ready.
- o_data  output  32  keystream word = i_state[k] + i_init[k] mod 2^32.
- o_idx  output  4  index k of the word on o_data.
- o_last  output  1  high with word 15.

Behaviour:
- Interface: one clock aclk; reset areset is asynchronous and active-high.
- Reset values: o_valid=0, o_last=0, o_idx=0, o_data=0, i_ready=0 while areset is high, FSM=IDLE, buffer=0.
- FSM states:
  - IDLE: i_ready=1. On i_valid, capture the block.
    - PIPELINE=0: go to STREAM.
    - PIPELINE=1: go to ADD.
  - ADD (PIPELINE=1 only): buffer word k <= state_k + init_k for all 16 words; i_ready=0; next cycle go to STREAM.
  - STREAM: o_valid=1, o_data=buffer[idx], o_idx=idx, o_last=(idx==15).
    - On o_ready: idx increments.
    - On the handshake at idx 15: idx wraps to 0 and the FSM leaves STREAM.
- Latency from accept to first o_valid: 1 cycle (PIPELINE=0), 2 cycles (PIPELINE=1). Then 16 words, one per cycle while o_ready=1.
- Back-to-back: during STREAM with idx==15 & o_ready, i_ready=1 combinationally.
  - If i_valid is also high, the new block is captured in the same cycle. The FSM goes to STREAM (PIPELINE=0) or ADD (PIPELINE=1) with zero bubble in mode 0.
  - Otherwise the FSM returns to IDLE.
- Otherwise i_ready=0 in ADD and STREAM; i_init/i_state are ignored.
- Backpressure: o_ready=0 holds o_data/o_idx/o_last stable; o_valid never drops mid-block.
- Arithmetic: per-word unsigned add, carry discarded, no inter-word carry. Byte order within words is unchanged.
- Reset mid-operation: the partial block is discarded. The next block restarts at idx 0.
- X/garbage on i_* while not accepting must not affect outputs.

Optional Feature:
- Macro: CHACHA_FINALIZE_XOR_EN.
- When defined, add ports:
  - i_text_valid  input  1
  - i_text_ready  output  1
  - i_text  input  32
- o_data = keystream word XOR i_text.
- A word transfers only when o_valid, o_ready and i_text_valid are all high.
- i_text_ready = STREAM & o_ready.
- o_valid = STREAM & i_text_valid.
- When undefined: no text ports; o_data is the raw keystream.

Test Plan:
- RFC 7539 2.3.2 vector: i_init word0=0x61707865, i_state word0=0x837778AB, o_ready=1 -> first word o_data=0xE4E7F110, o_idx=0; all 16 words match the reference model; o_last only on word 15.
- Wrap: i_state all 0xFFFFFFFF, i_init word k = k+1 -> o_data word k = k (0..15), 16 consecutive cycles, one cycle after accept (PIPELINE=0), two cycles after (PIPELINE=1).
- Backpressure: toggle o_ready pseudo-randomly -> no word lost or duplicated; o_data/o_idx stable while o_valid & !o_ready; i_ready=0 throughout the block.
- Back-to-back: i_valid held high with two blocks, PIPELINE=0, o_ready=1 -> 32 consecutive valid words; i_ready pulses on the word-15 cycle; second block starts at idx 0 the next cycle.
- Reset mid-block: assert areset asynchronously after word 5 -> o_valid=0 immediately. After release, i_ready=1; the next block streams from word 0 with correct sums.
- CHACHA_FINALIZE_XOR_EN: i_text=0xFFFFFFFF with the wrap vector -> o_data word k = ~k. Stalling i_text_valid stalls o_valid; i_text_ready mirrors o_ready in STREAM.

Source files
------------

// File: rtl/chacha_block_finalize.sv
`default_nettype none
// ============================================================================
//  Module   : chacha_block_finalize
//  Purpose  : Adds the original ChaCha input state to the 20-round state,
//             buffers the 512-bit keystream block, and streams it out as
//             sixteen 32-bit words over a valid/ready interface.
//  Options  : PIPELINE=0 adds at accept time. PIPELINE=1 stores the raw
//             states and adds them one cycle later, in the ADD state.
//             Defining CHACHA_FINALIZE_XOR_EN adds a text input stream.
//             Each output word is then the keystream word XOR the text word.
//  Revision : 1.0 - initial release
// ============================================================================
module chacha_block_finalize #(
  parameter int PIPELINE = 0
) (
  input  logic         aclk,
  input  logic         areset,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic [511:0] i_init,
  input  logic [511:0] i_state,
`ifdef CHACHA_FINALIZE_XOR_EN
  input  logic         i_text_valid,
  output logic         i_text_ready,
  input  logic [31:0]  i_text,
`endif
  output logic         o_valid,
  input  logic         o_ready,
  output logic [31:0]  o_data,
  output logic [3:0]   o_idx,
  output logic         o_last
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ADD    = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  // State entered after a block has been captured.
  localparam state_t c_fill_state = (PIPELINE != 0) ? S_ADD : S_STREAM;

  state_t      fsm_q, fsm_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] buf_q [16];

  logic        w_stream;
  logic        w_xfer;
  logic        w_blk_end;
  logic        w_accept;
  logic [31:0] w_word;

  assign w_stream = (fsm_q == S_STREAM);
  assign w_word   = buf_q[idx_q];

`ifdef CHACHA_FINALIZE_XOR_EN
  // A word moves only when the keystream, the text and the sink all line up.
  assign w_xfer       = w_stream & o_ready & i_text_valid;
  assign i_text_ready = w_stream & o_ready;
  assign o_valid      = w_stream & i_text_valid;
  assign o_data       = w_word ^ (w_stream ? i_text : 32'd0);
`else
  assign w_xfer  = w_stream & o_ready;
  assign o_valid = w_stream;
  assign o_data  = w_word;
`endif

  assign o_idx  = idx_q;
  assign o_last = w_stream & (idx_q == 4'd15);

  // Input handshake: free in IDLE, or on the last word of the current block
  // so a following block can be taken with no bubble.
  always_comb begin
    w_blk_end = w_xfer & (idx_q == 4'd15);
    i_ready   = ~areset & ((fsm_q == S_IDLE) | w_blk_end);
    w_accept  = i_valid & i_ready;
  end

  // Next-state and word-index logic.
  always_comb begin
    fsm_d = fsm_q;
    idx_d = idx_q;
    if (w_xfer) begin
      idx_d = idx_q + 4'd1;
    end
    case (fsm_q)
      S_IDLE: begin
        if (w_accept) begin
          fsm_d = c_fill_state;
        end
      end
      S_ADD: begin
        fsm_d = S_STREAM;
      end
      S_STREAM: begin
        if (w_blk_end) begin
          fsm_d = w_accept ? c_fill_state : S_IDLE;
        end
      end
      default: begin
        fsm_d = S_IDLE;
      end
    endcase
  end

  // FSM and index registers; a reset drops any partially streamed block.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      fsm_q <= S_IDLE;
      idx_q <= 4'd0;
    end else begin
      fsm_q <= fsm_d;
      idx_q <= idx_d;
    end
  end

  generate
    if (PIPELINE != 0) begin : g_pipe
      logic [31:0] init_q [16];

      // Capture raw states at accept, then fold in the init words during ADD.
      always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
          for (int k = 0; k < 16; k++) begin
            buf_q[k]  <= 32'd0;
            init_q[k] <= 32'd0;
          end
        end else if (w_accept) begin
          for (int k = 0; k < 16; k++) begin
            buf_q[k]  <= i_state[32*k +: 32];
            init_q[k] <= i_init[32*k +: 32];
          end
        end else if (fsm_q == S_ADD) begin
          for (int k = 0; k < 16; k++) begin
            buf_q[k] <= buf_q[k] + init_q[k];
          end
        end
      end
    end else begin : g_direct
      // Store the word-wise modular sum directly at accept.
      always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
          for (int k = 0; k < 16; k++) begin
            buf_q[k] <= 32'd0;
          end
        end else if (w_accept) begin
          for (int k = 0; k < 16; k++) begin
            buf_q[k] <= i_state[32*k +: 32] + i_init[32*k +: 32];
          end
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire
